plc_scan_ctrl: RTL and testbench
================================

PLC_SCAN_CTRL -- requirements
Module: plc_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_PERIOD, default 16, giving scan cycle length in clocks, legal range 4..65535.
REQ-002 The block SHALL have parameter WDT_LIMIT, default 8, giving maximum EXEC cycles before fault, legal range 2..65535.
REQ-003 The block SHALL have port clk_in, input, 1: single system clock, rising edge.
REQ-004 The block SHALL have port rst_in, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port a0_in, input, 16: analog pressure sample.
REQ-006 The block SHALL have port din_in, input, 2: asynchronous digital inputs, bit0 start, bit1 stop.
REQ-007 The block SHALL have port cpu_run_out, output, 1: CPU program-execution enable.
REQ-008 The block SHALL have port cpu_done_in, input, 1: single-cycle end-of-program pulse from the CPU.
REQ-009 The block SHALL have ports cpu_we_in, input, 1, and cpu_dout_in, input, 2: CPU output-image write (bit0 motor, bit1 max).
REQ-010 The block SHALL have ports img_a0_out, output, 16, and img_din_out, output, 2: input process image.
REQ-011 The block SHALL have port d_out, output, 2: physical outputs driven to d2 (motor) and d3 (max).
REQ-012 The block SHALL have ports overrun_out, output, 1, and wdt_fault_out, output, 1: sticky status flags.

Function
REQ-013 The FSM SHALL have states SAMPLE, EXEC, UPDATE, WAIT and FAULT.
REQ-014 din_in SHALL pass through a 2-flop synchronizer before use; a0_in SHALL NOT be synchronized.
REQ-015 SAMPLE SHALL last one cycle.
- img_a0_out <= a0_in; img_din_out <= synchronized din.
- pending output image <= current d_out.
- scan_cnt <= 0.
- next state EXEC.
REQ-016 cpu_run_out SHALL be 1 exactly while in EXEC and 0 otherwise; the image outputs SHALL stay stable outside SAMPLE.
REQ-017 In EXEC, cpu_we_in=1 SHALL load cpu_dout_in into the pending image; cpu_we_in and cpu_done_in SHALL be ignored in all other states.
REQ-018 In EXEC, cpu_done_in=1 SHALL move the FSM to UPDATE next cycle; a write presented in the same cycle SHALL still be captured.
REQ-019 exec_cnt SHALL clear on EXEC entry and increment each EXEC cycle.
- exec_cnt == WDT_LIMIT-1 without done -> FAULT.
- done in the same cycle as the limit -> done wins, FSM goes to UPDATE.
REQ-020 UPDATE SHALL last one cycle and load d_out <= pending image.
- if scan_cnt >= SCAN_PERIOD-1: next state SAMPLE, set overrun_out.
- otherwise: next state WAIT.
REQ-021 WAIT SHALL move to SAMPLE when scan_cnt == SCAN_PERIOD-1, so SAMPLE entries are spaced exactly SCAN_PERIOD clocks when there is no overrun.
REQ-022 scan_cnt SHALL be 16 bits, increment every non-SAMPLE cycle, and saturate at 0xFFFF.
REQ-023 FAULT SHALL be absorbing until reset.
- d_out forced to 2'b00 (motor off) on FAULT entry.
- wdt_fault_out=1; cpu_run_out=0.
- all CPU inputs ignored.
REQ-024 overrun_out SHALL be sticky until reset and SHALL NOT stop scanning.

Reset
REQ-025 rst_in=1 SHALL on the next edge set state=SAMPLE and clear all registers: d_out, images, pending, counters, flags, synchronizer.
REQ-026 Reset SHALL take priority over every event, including mid-EXEC and in FAULT; the first SAMPLE occurs the cycle after rst_in deasserts.

Structure
REQ-027 A shared package plc_pkg SHALL hold the FSM state enum, the DIN/DOUT bit-index constants (START=0, STOP=1, MOTOR=0, MAX=1) and the default SCAN_PERIOD/WDT_LIMIT values.
REQ-028 The synchronizer SHALL be a separate sub-module sync2 (parameterized width), instantiated once with width 2.

Verification
REQ-029 With SCAN_PERIOD=16, WDT_LIMIT=8, cpu_done_in pulsed on the 3rd EXEC cycle: SAMPLE SHALL recur every 16 clocks, cpu_run_out SHALL be high 3 cycles per scan, and overrun_out SHALL stay 0.
REQ-030 a0_in=0x1234 at SAMPLE, then changed to 0xFFFF mid-scan: img_a0_out SHALL hold 0x1234 until the next SAMPLE, then show 0xFFFF.
REQ-031 cpu_we_in with dout=2'b01, then done: d_out SHALL change to 01 exactly in the cycle after UPDATE, never during EXEC.
REQ-032 cpu_done_in never asserted: FAULT SHALL be entered after 8 EXEC cycles, with d_out=00 and wdt_fault_out=1 held until rst_in.
REQ-033 Done delayed to the 14th EXEC cycle, with WDT_LIMIT=20: overrun_out SHALL be set and SAMPLE SHALL follow UPDATE directly.
REQ-034 rst_in pulsed mid-EXEC with d_out=01: d_out SHALL be 00 and all flags 0 the next cycle, and SAMPLE SHALL occur one cycle after release.

Source files
------------

// File: rtl/plc_pkg.sv
// Shared types and constants for the PLC scan-cycle controller.
package plc_pkg;

    typedef enum logic [2:0] {
        ST_SAMPLE,
        ST_EXEC,
        ST_UPDATE,
        ST_WAIT,
        ST_FAULT
    } plc_state_e;

    // Bit positions inside the digital input and output images
    localparam int unsigned DIN_START  = 0;
    localparam int unsigned DIN_STOP   = 1;
    localparam int unsigned DOUT_MOTOR = 0;
    localparam int unsigned DOUT_MAX   = 1;

    localparam int unsigned DEF_SCAN_PERIOD = 16;
    localparam int unsigned DEF_WDT_LIMIT   = 8;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned A0_W  = 16;
    localparam int unsigned DIO_W = 2;

endpackage

// File: rtl/plc_scan_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/plc_scan_ctrl.sv
// PLC scan-cycle controller: sample inputs, run CPU program, update outputs, wait.
module plc_scan_ctrl
    import plc_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD = DEF_SCAN_PERIOD,
    parameter int unsigned WDT_LIMIT   = DEF_WDT_LIMIT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] a0_in,
    input  logic [1:0]  din_in,
    output logic        cpu_run_out,
    input  logic        cpu_done_in,
    input  logic        cpu_we_in,
    input  logic [1:0]  cpu_dout_in,
    output logic [15:0] img_a0_out,
    output logic [1:0]  img_din_out,
    output logic [1:0]  d_out,
    output logic        overrun_out,
    output logic        wdt_fault_out
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_LIMIT - 1);

    plc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [CNT_W-1:0]  exec_cnt_q, exec_cnt_d;
    logic [A0_W-1:0]   img_a0_q, img_a0_d;
    logic [DIO_W-1:0]  img_din_q, img_din_d;
    logic [DIO_W-1:0]  pend_q, pend_d;
    logic [DIO_W-1:0]  dout_q, dout_d;
    logic              run_q, run_d;
    logic              ovr_q, ovr_d;
    logic              wdt_q, wdt_d;
    logic [DIO_W-1:0]  din_sync;

    sync2 #(.WIDTH(DIO_W)) u_din_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (din_in),
        .q_out  (din_sync)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_SAMPLE;
            scan_cnt_q <= '0;
            exec_cnt_q <= '0;
            img_a0_q   <= '0;
            img_din_q  <= '0;
            pend_q     <= '0;
            dout_q     <= '0;
            run_q      <= 1'b0;
            ovr_q      <= 1'b0;
            wdt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            exec_cnt_q <= exec_cnt_d;
            img_a0_q   <= img_a0_d;
            img_din_q  <= img_din_d;
            pend_q     <= pend_d;
            dout_q     <= dout_d;
            run_q      <= run_d;
            ovr_q      <= ovr_d;
            wdt_q      <= wdt_d;
        end
    end

    // Period decisions use the post-increment count so SAMPLE recurs every SCAN_PERIOD clocks
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = (scan_cnt_q == '1) ? scan_cnt_q : scan_cnt_q + 1'b1;
        exec_cnt_d = exec_cnt_q;
        img_a0_d   = img_a0_q;
        img_din_d  = img_din_q;
        pend_d     = pend_q;
        dout_d     = dout_q;
        ovr_d      = ovr_q;
        wdt_d      = wdt_q;

        case (state_q)
            ST_SAMPLE: begin
                img_a0_d   = a0_in;
                img_din_d  = din_sync;
                pend_d     = dout_q;
                scan_cnt_d = '0;
                exec_cnt_d = '0;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                exec_cnt_d = exec_cnt_q + 1'b1;
                if (cpu_we_in) begin
                    pend_d = cpu_dout_in;
                end
                if (cpu_done_in) begin
                    state_d = ST_UPDATE;
                end else if (exec_cnt_q == WDT_LAST) begin
                    state_d = ST_FAULT;
                    dout_d  = '0;
                    wdt_d   = 1'b1;
                end
            end
            ST_UPDATE: begin
                dout_d = pend_q;
                if (scan_cnt_d >= SCAN_LAST) begin
                    state_d = ST_SAMPLE;
                    ovr_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (scan_cnt_d == SCAN_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_FAULT: begin
                dout_d = '0;
                wdt_d  = 1'b1;
            end
            default: begin
                state_d = ST_SAMPLE;
            end
        endcase

        run_d = (state_d == ST_EXEC);
    end

    assign cpu_run_out   = run_q;
    assign img_a0_out    = img_a0_q;
    assign img_din_out   = img_din_q;
    assign d_out         = dout_q;
    assign overrun_out   = ovr_q;
    assign wdt_fault_out = wdt_q;

endmodule

// File: tb/tb_plc_scan_ctrl.sv
// Self-checking bench for plc_scan_ctrl: vector table, hand sequences and random scans.
module tb_plc_scan_ctrl;

    localparam int P = 16;

    logic        clk;
    logic        rst;
    logic [15:0] a0;
    logic [1:0]  din;
    logic        cpu_done;
    logic        cpu_we;
    logic [1:0]  cpu_dout;
    logic        sel;

    logic        run1, run2, ovr1, ovr2, wdt1, wdt2;
    logic [15:0] ia1, ia2;
    logic [1:0]  id1, id2, do1, do2;

    logic        o_run, o_ovr, o_wdt;
    logic [15:0] o_ia;
    logic [1:0]  o_id, o_do;

    int n_chk  = 0;
    int n_fail = 0;

    // Scan-level reference state
    logic [15:0] m_a0;
    logic [1:0]  m_img_din;
    logic [1:0]  m_din_src;
    logic [1:0]  m_dout;
    logic        m_ovr;
    bit          m_flt;

    plc_scan_ctrl #(.SCAN_PERIOD(16), .WDT_LIMIT(8)) dut (
        .clk_in(clk), .rst_in(rst), .a0_in(a0), .din_in(din),
        .cpu_run_out(run1), .cpu_done_in(cpu_done), .cpu_we_in(cpu_we),
        .cpu_dout_in(cpu_dout), .img_a0_out(ia1), .img_din_out(id1),
        .d_out(do1), .overrun_out(ovr1), .wdt_fault_out(wdt1)
    );

    plc_scan_ctrl #(.SCAN_PERIOD(16), .WDT_LIMIT(20)) dut20 (
        .clk_in(clk), .rst_in(rst), .a0_in(a0), .din_in(din),
        .cpu_run_out(run2), .cpu_done_in(cpu_done), .cpu_we_in(cpu_we),
        .cpu_dout_in(cpu_dout), .img_a0_out(ia2), .img_din_out(id2),
        .d_out(do2), .overrun_out(ovr2), .wdt_fault_out(wdt2)
    );

    assign o_run = sel ? run2 : run1;
    assign o_ovr = sel ? ovr2 : ovr1;
    assign o_wdt = sel ? wdt2 : wdt1;
    assign o_ia  = sel ? ia2  : ia1;
    assign o_id  = sel ? id2  : id1;
    assign o_do  = sel ? do2  : do1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with all CPU inputs active to show reset priority
    task automatic do_reset();
        rst      = 1'b1;
        cpu_done = 1'b1;
        cpu_we   = 1'b1;
        cpu_dout = 2'b11;
        a0       = 16'($urandom);
        step();
        chk("rst_run",     32'(o_run), 32'(0));
        chk("rst_img_a0",  32'(o_ia),  32'(0));
        chk("rst_img_din", 32'(o_id),  32'(0));
        chk("rst_dout",    32'(o_do),  32'(0));
        chk("rst_ovr",     32'(o_ovr), 32'(0));
        chk("rst_wdt",     32'(o_wdt), 32'(0));
        step();
        rst       = 1'b0;
        m_a0      = '0;
        m_img_din = '0;
        m_din_src = '0;
        m_dout    = '0;
        m_ovr     = 1'b0;
        m_flt     = 1'b0;
    endtask

    // One scan starting in its SAMPLE cycle; d = EXEC cycle of done (0 = never)
    task automatic run_scan(input int d, input int we_at, input logic [1:0] we_val,
                            input logic [15:0] a0v, input logic [1:0] dinv,
                            output int runs_seen);
        int W, last_exec, u, L;
        bit flt, ovr_new;
        logic [1:0] pend;
        W         = sel ? 20 : 8;
        flt       = (d <= 0) || (d > W);
        last_exec = flt ? W : d;
        u         = d + 1;
        ovr_new   = !flt && (u >= P - 1);
        L         = flt ? W + 5 : (ovr_new ? u + 1 : P);
        pend      = m_dout;
        if (we_at >= 1 && we_at <= last_exec) pend = we_val;
        runs_seen = 0;
        for (int k = 0; k < L; k++) begin
            bit in_exec;
            logic [1:0] exp_do;
            in_exec = (k >= 1) && (k <= last_exec);
            if (flt) exp_do = (k <= W) ? m_dout : 2'b00;
            else     exp_do = (k <= u) ? m_dout : pend;
            chk("scan_run",     32'(o_run), 32'(in_exec));
            chk("scan_img_a0",  32'(o_ia),  32'((k == 0) ? m_a0 : a0v));
            chk("scan_img_din", 32'(o_id),  32'((k == 0) ? m_img_din : m_din_src));
            chk("scan_dout",    32'(o_do),  32'(exp_do));
            chk("scan_ovr",     32'(o_ovr), 32'(m_ovr));
            chk("scan_wdt",     32'(o_wdt), 32'(flt && (k > W)));
            if (o_run) runs_seen++;
            a0 = (k == 0) ? a0v : 16'($urandom);
            if (k == 0) din = dinv;
            if (in_exec) begin
                cpu_done = !flt && (k == d);
                cpu_we   = (k == we_at);
                cpu_dout = (k == we_at) ? we_val : 2'($urandom);
            end else begin
                cpu_done = 1'($urandom);
                cpu_we   = 1'($urandom);
                cpu_dout = 2'($urandom);
            end
            step();
        end
        m_a0      = a0v;
        m_img_din = m_din_src;
        m_din_src = dinv;
        m_dout    = flt ? 2'b00 : pend;
        m_ovr     = m_ovr | ovr_new;
        m_flt     = flt;
    endtask

    typedef struct {
        int          rst_before;
        int          sel;
        int          done_at;
        int          we_at;
        logic [1:0]  we_val;
        logic [15:0] a0v;
        logic [1:0]  dinv;
        int          exp_runs;
        logic [1:0]  exp_dout;
        logic        exp_ovr;
        logic        exp_wdt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int runs;
        rst = 1'b1; a0 = '0; din = '0; cpu_done = 1'b0; cpu_we = 1'b0; cpu_dout = '0; sel = 1'b0;

        //         rst sel done we  wval   a0        din    runs dout   ovr   wdt
        tbl[0]  = '{1, 0, 3,  2,  2'b01, 16'h1234, 2'b01, 3,  2'b01, 1'b0, 1'b0};
        tbl[1]  = '{0, 0, 3,  0,  2'b11, 16'hFFFF, 2'b10, 3,  2'b01, 1'b0, 1'b0};
        tbl[2]  = '{0, 0, 8,  8,  2'b10, 16'h0000, 2'b11, 8,  2'b10, 1'b0, 1'b0};
        tbl[3]  = '{0, 0, 1,  1,  2'b11, 16'hA5A5, 2'b00, 1,  2'b11, 1'b0, 1'b0};
        tbl[4]  = '{0, 0, 0,  3,  2'b01, 16'h5A5A, 2'b01, 8,  2'b00, 1'b0, 1'b1};
        tbl[5]  = '{1, 1, 14, 14, 2'b01, 16'h0F0F, 2'b01, 14, 2'b01, 1'b1, 1'b0};
        tbl[6]  = '{0, 1, 3,  0,  2'b10, 16'h1111, 2'b10, 3,  2'b01, 1'b1, 1'b0};
        tbl[7]  = '{0, 1, 13, 5,  2'b10, 16'h2222, 2'b11, 13, 2'b10, 1'b1, 1'b0};
        tbl[8]  = '{0, 1, 20, 0,  2'b01, 16'h3333, 2'b00, 20, 2'b10, 1'b1, 1'b0};
        tbl[9]  = '{0, 1, 0,  4,  2'b11, 16'h4444, 2'b01, 20, 2'b00, 1'b1, 1'b1};
        tbl[10] = '{1, 0, 5,  5,  2'b11, 16'hBEEF, 2'b10, 5,  2'b11, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            sel = (tbl[i].sel != 0);
            if (tbl[i].rst_before != 0) do_reset();
            run_scan(tbl[i].done_at, tbl[i].we_at, tbl[i].we_val, tbl[i].a0v, tbl[i].dinv, runs);
            chk("tbl_runs", 32'(runs),  32'(tbl[i].exp_runs));
            chk("tbl_dout", 32'(o_do),  32'(tbl[i].exp_dout));
            chk("tbl_ovr",  32'(o_ovr), 32'(tbl[i].exp_ovr));
            chk("tbl_wdt",  32'(o_wdt), 32'(tbl[i].exp_wdt));
        end

        // Reset in the middle of EXEC with motor on
        sel = 1'b0;
        do_reset();
        run_scan(2, 1, 2'b01, 16'h1234, 2'b00, runs);
        chk("mid_rst_pre_dout", 32'(o_do), 32'(2'b01));
        cpu_done = 1'b0; cpu_we = 1'b0;
        step();
        chk("mid_rst_exec1", 32'(o_run), 32'(1));
        step();
        chk("mid_rst_exec2", 32'(o_run), 32'(1));
        rst = 1'b1; cpu_done = 1'b1; cpu_we = 1'b1; cpu_dout = 2'b10;
        step();
        chk("mid_rst_dout", 32'(o_do),  32'(0));
        chk("mid_rst_ovr",  32'(o_ovr), 32'(0));
        chk("mid_rst_wdt",  32'(o_wdt), 32'(0));
        chk("mid_rst_run",  32'(o_run), 32'(0));
        rst = 1'b0; cpu_done = 1'b0; cpu_we = 1'b0;
        chk("rel_sample_run", 32'(o_run), 32'(0));
        step();
        chk("rel_exec_run", 32'(o_run), 32'(1));

        // Randomized scans against the scan-level model
        for (int g = 0; g < 6; g++) begin
            sel = 1'($urandom);
            do_reset();
            for (int s = 0; s < 8; s++) begin
                int W, d, we_at;
                W     = sel ? 20 : 8;
                d     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, W));
                we_at = int'($urandom_range(0, W));
                run_scan(d, we_at, 2'($urandom), 16'($urandom), 2'($urandom), runs);
                if (m_flt) break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
